// File: rtl/cla_pkg.sv
// Shared definitions for the round-robin CLA adder arbiter.
//   CLA_WIDTH   : default operand/sum width of the shared adder
//   arb_state_e : arbiter FSM encoding (ARB=0, LOCK=1)
//   clog2()     : ceiling log2, used to size requester tags and the RR pointer
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 64;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_rr_pick.sv
// Combinational circular priority pick.
// Scans requesters starting at i_ptr and wrapping past N-1; the first one
// with its request bit set wins.
//   i_req   [N]  request vector
//   i_ptr   [PW] highest-priority index this cycle (< N)
//   o_grant [N]  one-hot winner, zero when no request
//   o_idx   [PW] winner index (0 when no request)
//   o_any        any request present
module cla_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one registered CLA adder among NREQ requesters.
// Issues at most one operand pair per cycle, carries the owner tag alongside
// the adder latency and returns sum/carry as a one-hot registered pulse.
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_req_valid/lock [NREQ] per-requester valid and burst-lock
//   i_req_op1/op2            packed operands, slice i = [i*WIDTH +: WIDTH]
//   o_req_ready [NREQ]       one-hot combinational grant
//   o_add_op1/op2, i_add_sum/cout   shared adder interface
//   o_rsp_valid [NREQ], o_rsp_sum, o_rsp_cout   result return
// Build option CLA_ARB_STATS_EN adds o_grant_cnt [NREQ*16]: saturating
// per-requester transfer counters.
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = CLA_WIDTH,
  parameter int ADD_LAT = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ-1:0]       i_req_lock,
  input  logic [NREQ*WIDTH-1:0] i_req_op1,
  input  logic [NREQ*WIDTH-1:0] i_req_op2,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]      o_add_op1,
  output logic [WIDTH-1:0]      o_add_op2,
  input  logic [WIDTH-1:0]      i_add_sum,
  input  logic                  i_add_cout,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_sum,
  output logic                  o_rsp_cout
`ifdef CLA_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    o_grant_cnt
`endif
);

  localparam int TW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

  arb_state_e       r_state, w_state_nxt;
  logic [TW-1:0]    r_ptr, w_ptr_nxt;
  logic [TW-1:0]    r_owner, w_owner_nxt;
  logic [NREQ-1:0]  w_pick_grant;
  logic [TW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_xfer;
  logic [TW-1:0]    w_xfer_idx;

  logic [WIDTH-1:0] r_add_op1, r_add_op2;
  logic [ADD_LAT:0] r_pv;
  logic [TW-1:0]    r_pt [ADD_LAT+1];
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;

  cla_rr_pick #(.N(NREQ), .PW(TW)) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Ready is held low during reset so nothing is accepted while the pipe clears.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    o_req_ready = '0;
    w_xfer      = 1'b0;
    w_xfer_idx  = r_owner;
    if (!i_reset) begin
      case (r_state)
        ST_ARB: begin
          o_req_ready = w_pick_grant;
          w_xfer      = w_pick_any;
          w_xfer_idx  = w_pick_idx;
          if (w_pick_any) begin
            w_ptr_nxt = (w_pick_idx == TW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
            if (i_req_lock[w_pick_idx]) begin
              w_state_nxt = ST_LOCK;
              w_owner_nxt = w_pick_idx;
            end
          end
        end
        ST_LOCK: begin
          if (i_req_valid[r_owner]) begin
            o_req_ready[r_owner] = 1'b1;
            w_xfer               = 1'b1;
            if (!i_req_lock[r_owner]) w_state_nxt = ST_ARB;
          end
        end
        default: w_state_nxt = ST_ARB;
      endcase
    end
  end

  // Stage 0 is loaded alongside the operand registers; the last stage lines up
  // with the adder output, which is captured into the response registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_add_op1   <= '0;
      r_add_op2   <= '0;
      r_pv        <= '0;
      for (int s = 0; s <= ADD_LAT; s++) r_pt[s] <= '0;
      r_rsp_valid <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_add_op1 <= i_req_op1[int'(w_xfer_idx)*WIDTH +: WIDTH];
        r_add_op2 <= i_req_op2[int'(w_xfer_idx)*WIDTH +: WIDTH];
      end
      r_pv[0] <= w_xfer;
      r_pt[0] <= w_xfer_idx;
      for (int s = 1; s <= ADD_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pt[s] <= r_pt[s-1];
      end
      r_rsp_valid <= '0;
      if (r_pv[ADD_LAT]) begin
        r_rsp_valid[r_pt[ADD_LAT]] <= 1'b1;
        r_rsp_sum                  <= i_add_sum;
        r_rsp_cout                 <= i_add_cout;
      end
    end
  end

  assign o_add_op1   = r_add_op1;
  assign o_add_op2   = r_add_op2;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;

`ifdef CLA_ARB_STATS_EN
  logic [15:0] r_gcnt [NREQ];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NREQ; i++) r_gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_xfer && (w_xfer_idx == TW'(i)) && (r_gcnt[i] != 16'hffff))
          r_gcnt[i] <= r_gcnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign o_grant_cnt[g*16 +: 16] = r_gcnt[g];
  end
`endif

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter (NREQ=4, WIDTH=64, ADD_LAT=1) with a
// registered a+b adder model. With CLA_ARB_STATS_EN defined the saturating
// grant counters are also exercised.
module tb_cla_add_arbiter;
  import cla_pkg::*;

  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_lock;
  logic [255:0]  req_op1;
  logic [255:0]  req_op2;
  logic [3:0]    req_ready;
  logic [63:0]   add_op1, add_op2;
  logic [63:0]   add_sum;
  logic          add_cout;
  logic [3:0]    rsp_valid;
  logic [63:0]   rsp_sum;
  logic          rsp_cout;
`ifdef CLA_ARB_STATS_EN
  logic [63:0]   grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cla_add_arbiter #(.NREQ(4), .WIDTH(64), .ADD_LAT(1)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .i_req_lock  (req_lock),
    .i_req_op1   (req_op1),
    .i_req_op2   (req_op2),
    .o_req_ready (req_ready),
    .o_add_op1   (add_op1),
    .o_add_op2   (add_op2),
    .i_add_sum   (add_sum),
    .i_add_cout  (add_cout),
    .o_rsp_valid (rsp_valid),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_cout  (rsp_cout)
`ifdef CLA_ARB_STATS_EN
    ,
    .o_grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) {add_cout, add_sum} <= {1'b0, add_op1} + {1'b0, add_op2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_op1 = '0;
    req_op2 = '0;
    do_reset();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (add_op1 !== 64'd0 || add_op2 !== 64'd0) begin errors++; $display("FAIL reset_addop got %h/%h exp 0", add_op1, add_op2); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp got v=%b s=%h c=%b exp 0", rsp_valid, rsp_sum, rsp_cout); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_op1[63:0] = 64'hf20f_ffff_ffff_ffff;
    req_op2[63:0] = 64'hffff_ffff_ffff_ff50;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early1 got %b exp 0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early2 got %b exp 0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
    checks++; if (rsp_sum !== 64'hf20f_ffff_ffff_ff4f || rsp_cout !== 1'b1) begin errors++; $display("FAIL single_sum got %h c=%b exp f20fffffffffff4f c=1", rsp_sum, rsp_cout); end
    tick();
    checks++; if (rsp_valid !== 4'b0000 || rsp_sum !== 64'hf20f_ffff_ffff_ff4f) begin errors++; $display("FAIL single_hold got v=%b s=%h exp 0000 f20fffffffffff4f", rsp_valid, rsp_sum); end
  endtask

  task automatic test_contention();
    int exp_g [5];
    logic [63:0] o1 [4];
    logic [63:0] o2 [4];
    exp_g = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      o1[i] = 64'h0000_0001_0000_0000 * (i + 1);
      o2[i] = 64'(i + 5);
      req_op1[i*64 +: 64] = o1[i];
      req_op2[i*64 +: 64] = o2[i];
    end
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 5) begin
        checks++;
        if (req_ready !== (4'b0001 << exp_g[c])) begin errors++; $display("FAIL contention_grant%0d got %b exp %0d", c, req_ready, exp_g[c]); end
      end
      tick();
      if (c >= 2) begin
        int g;
        g = exp_g[c-2];
        checks++;
        if (rsp_valid !== (4'b0001 << g) || rsp_sum !== o1[g] + o2[g] || rsp_cout !== 1'b0) begin
          errors++;
          $display("FAIL contention_rsp%0d got v=%b s=%h exp owner %0d s=%h", c - 2, rsp_valid, rsp_sum, g, o1[g] + o2[g]);
        end
      end
    end
  endtask

  task automatic test_lock();
    req_valid = 4'b0100; req_lock = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_first got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1011; req_lock = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lock_owner_idle got %b exp 0000", req_ready); end
    tick();
    req_valid = 4'b1111; req_lock = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_second got %b exp 0100", req_ready); end
    tick();
    req_lock = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_third got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1011;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_resume3 got %b exp 1000", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_resume0 got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b0010;
    req_op1[127:64] = 64'h1234_5678_9abc_def0;
    req_op2[127:64] = 64'h0fed_cba9_8765_4321;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midflight_grant got %b exp 0010", req_ready); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midflight_ready_in_reset got %b exp 0000", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midflight_rsp%0d got %b exp 0000", c, rsp_valid); end
      tick();
    end
    checks++;
    if (add_op1 !== 64'd0 || add_op2 !== 64'd0 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midflight_outputs got op=%h/%h s=%h c=%b r=%b exp all 0", add_op1, add_op2, rsp_sum, rsp_cout, req_ready);
    end
  endtask

  task automatic test_back_to_back_wrap();
    req_valid = 4'b0001;
    req_op1[63:0] = 64'hffff_ffff_ffff_ffff;
    req_op2[63:0] = 64'hffff_ffff_ffff_ffff;
    tick();
    req_op1[63:0] = 64'd0;
    req_op2[63:0] = 64'd0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== 64'hffff_ffff_ffff_fffe || rsp_cout !== 1'b1) begin errors++; $display("FAIL wrap_ones got v=%b s=%h c=%b exp 0001 fffffffffffffffe 1", rsp_valid, rsp_sum, rsp_cout); end
    tick();
    checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0) begin errors++; $display("FAIL wrap_zero got v=%b s=%h c=%b exp 0001 0 0", rsp_valid, rsp_sum, rsp_cout); end
    tick();
  endtask

`ifdef CLA_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req_valid = 4'b1000;
    for (int c = 0; c < 70000; c++) tick();
    req_valid = '0;
    tick();
    checks++; if (grant_cnt[63:48] !== 16'hffff) begin errors++; $display("FAIL stats_req3 got %h exp ffff", grant_cnt[63:48]); end
    checks++; if (grant_cnt[47:0] !== 48'd0) begin errors++; $display("FAIL stats_others got %h exp 0", grant_cnt[47:0]); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    req_op1 = '0;
    req_op2 = '0;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_reset_midflight();
    test_back_to_back_wrap();
`ifdef CLA_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
